// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM with programmable wait states and a side preload port.
// Define AVALON_RAM_ACCESS_COUNT_EN to add saturating rd_count/wr_count outputs.
module avalon_wait_ram #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic              waitrequest,
   output logic [31:0]       readdata,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [31:0]       load_data
`ifdef AVALON_RAM_ACCESS_COUNT_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);

   localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

   state_e            state_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       rdata_q;
   logic [31:0]       mem_q [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic              req;
   logic              leave_done;
   logic              unused_addr;

   assign idx         = address[ADDR_W+1:2];
   assign req         = read | write;
   assign leave_done  = (state_q == DONE) && !load_en;
   assign waitrequest = (req && (state_q != DONE)) || load_en;
   assign readdata    = rdata_q;
   assign unused_addr = ^{address[31:ADDR_W+2], address[1:0]};

   // A preload freezes the handshake entirely; the bus resumes where it left off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else if (!load_en) begin
         unique case (state_q)
            IDLE: begin
               if (req) begin
                  if (WAIT_CYCLES == 0) begin
                     state_q <= DONE;
                     rdata_q <= mem_q[idx];
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CW'(WAIT_CYCLES);
                  end
               end
            end
            WAIT: begin
               if (!req) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CW'(1)) begin
                  state_q <= DONE;
                  cnt_q   <= '0;
                  rdata_q <= mem_q[idx];
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Array is deliberately not reset; preload and bus writes never coincide.
   always_ff @(posedge clk) begin
      if (load_en) begin
         mem_q[load_addr] <= load_data;
      end else if (leave_done && write) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) mem_q[idx][8*b +: 8] <= writedata[8*b +: 8];
         end
      end
   end

`ifdef AVALON_RAM_ACCESS_COUNT_EN
   logic [15:0] rd_cnt_q;
   logic [15:0] wr_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (leave_done) begin
         if (write) begin
            if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
         end else if (read) begin
            if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
         end
      end
   end

   assign rd_count = rd_cnt_q;
   assign wr_count = wr_cnt_q;
`endif

endmodule

// File: doc/avalon_wait_ram.md
Name: avalon_wait_ram

Overview:
- Avalon-MM slave memory sitting directly downstream of top_level_cpu on its bus. Serves the CPU's instruction fetches and data loads/stores.
- Programmable wait states exercise the CPU's waitrequest stall handling.
- Side preload port lets benches write program words and data before releasing the CPU.
- Word-organised array; byte lanes selected by byteenable.

Parameters:
- ADDR_W, 8, word-index width; array depth 2**ADDR_W words.
- WAIT_CYCLES, 2, extra stall cycles per access (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- address  input  32  byte address from master; word index = address[ADDR_W+1:2]; upper bits ignored (aliasing).
- read  input  1  read request.
- write  input  1  write request.
- writedata  input  32  store data.
- byteenable  input  4  lane enables; bit i covers bits [8i+7:8i].
- waitrequest  output  1  stall master while high.
- readdata  output  32  read data, valid in the cycle waitrequest is low for a read.
- load_en  input  1  preload strobe.
- load_addr  input  ADDR_W  preload word index.
- load_data  input  32  preload word.

Behaviour:
- State machine states: IDLE, WAIT, DONE.
- Reset (reset=0):
  - state=IDLE, counter=0, readdata=0.
  - Memory array is not cleared.
- IDLE:
  - read|write high and load_en low -> go to WAIT with counter=WAIT_CYCLES. If WAIT_CYCLES=0, go straight to DONE.
- WAIT:
  - Decrement counter; at 0 go to DONE.
- DONE:
  - readdata registered from array[index] on entry.
  - Write commits on the rising edge leaving DONE, only to lanes with byteenable set.
  - Next state is IDLE.
- waitrequest (combinational) = (read|write) & (state!=DONE), OR load_en.
  - Each access sees WAIT_CYCLES+1 cycles with waitrequest high, then 1 cycle low.
  - Back-to-back accesses pass through IDLE once, so there is one stall cycle between accesses.
- Master must hold address, read, write, writedata and byteenable stable while waitrequest is high. If read and write both drop before DONE, return to IDLE with no write.
- read and write both high: treated as a write. readdata is still loaded with the pre-write word.
- byteenable=0 on a write: handshake completes, array unchanged.
- load_en:
  - Writes load_data to array[load_addr] on each rising edge (full word).
  - Priority over the bus; state is held while load_en is high.
- Reset asserted mid-access: immediate return to IDLE, pending write discarded, readdata=0.
- readdata holds its last value outside DONE.

Optional Feature:
- Macro: AVALON_RAM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments by 1 on leaving DONE for a read or write respectively (read+write counts as write).
  - Both saturate at 16'hFFFF and reset to 0.
  - Preloads are not counted.
- Undefined: ports absent; behaviour otherwise identical.

Test Plan:
- Preload load_addr=8'h06, load_data=32'h45, then read address=32'hBFC00018 -> waitrequest high 3 cycles, then low 1 cycle with readdata=32'h00000045.
- Preload word 6=32'h11223344, write address=32'h18, writedata=32'hAABBCCDD, byteenable=4'b0101, then read back -> 32'h11BB33DD.
- WAIT_CYCLES=0 build, read word 6 -> waitrequest high exactly 1 cycle, readdata valid next cycle.
- Write started with 32'hDEADBEEF, reset driven to 0 during WAIT -> readdata=0, state IDLE, later read returns the old word unchanged.
- load_en high during a pending read -> waitrequest stays high; read completes WAIT_CYCLES+1 cycles after load_en falls, returning the freshly loaded value when addresses match.
- With AVALON_RAM_ACCESS_COUNT_EN: 3 reads + 2 writes + 1 simultaneous read/write -> rd_count=3, wr_count=3.
